fabric_driver: RTL



---
 rtl/fabric_driver.sv | 83 ++++++++
 1 files changed

// File: rtl/fabric_driver.sv
// rtl/fabric_driver.sv - pairs IO bytes into a four-lane frame held HOLD_CYCLES on the fabric inputs
// Optional: FABRIC_DRIVER_AUTOCLEAR_EN zeroes the lanes when the hold period ends.
module fabric_driver #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       flush,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3,
    output logic [3:0] out4,
    output logic       frame_done,
    output logic [7:0] frame_count
);

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HALF, HOLD} state_t;

    state_t     state;
    logic [7:0] shadow;
    logic [7:0] hold_cnt;

    assign wr_ready = (state != HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shadow      <= '0;
            hold_cnt    <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            out4        <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_valid) begin
                        shadow <= wr_data;
                        state  <= HALF;
                    end
                end
                HALF: begin
                    // flush beats a simultaneous byte; that byte is dropped
                    if (flush) begin
                        state <= IDLE;
                    end else if (wr_valid) begin
                        out1        <= shadow[3:0];
                        out2        <= shadow[7:4];
                        out3        <= wr_data[3:0];
                        out4        <= wr_data[7:4];
                        hold_cnt    <= HOLD_INIT;
                        frame_count <= frame_count + 8'd1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
`ifdef FABRIC_DRIVER_AUTOCLEAR_EN
                        out1 <= '0;
                        out2 <= '0;
                        out3 <= '0;
                        out4 <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
